fet_sel_seq: RTL and testbench
==============================

Name: fet_sel_seq

Overview:
- Parametrised, registered successor to the 5-to-32 FET select decoder.
- Drives a one-hot FET enable bus with a guaranteed all-off break-before-make gap whenever the selected channel changes.
- Two modes: manual (channel follows an input) and scan (automatic sweep over a channel window, with a programmable dwell per channel).
- Sits between the measurement controller and the FET switch array of the sensor front end.

Parameters:
- SEL_W, 5: channel index width.
- N_OUT, 2**SEL_W: number of FET enables; must be ≤ 2**SEL_W.
- DWELL_W, 16: dwell counter width.
- GAP_W, 4: break-before-make counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low forces all FETs off.
- mode  in  1  0 = manual, 1 = scan.
- sel_in  in  SEL_W  manual channel select.
- start  in  1  scan start pulse.
- first  in  SEL_W  scan first channel.
- last  in  SEL_W  scan last channel (inclusive).
- dwell  in  DWELL_W  on-cycles per scan channel; 0 is treated as 1.
- gap  in  GAP_W  all-off cycles between channels.
- out  out  N_OUT  registered one-hot FET enables.
- ch  out  SEL_W  current or pending channel index.
- busy  out  1  high in GAP or ON during a scan.
- settled  out  1  high while out is a valid one-hot (state ON).
- done  out  1  one-cycle pulse after the last scan channel completes.

Behaviour:
- Reset: synchronous, active-high; when rst is high at a clk edge, all outputs go to 0 and state goes to IDLE.
- States: IDLE, GAP, ON.
- In all states, out = one-hot(ch) when the state is ON, and all zero otherwise. out is a registered output.
- Indices ≥ N_OUT are illegal:
  - Manual mode: out stays all zero.
  - Scan mode: the scan skips the index.
- en low (any state):
  - Next cycle: state IDLE, out = 0, settled = 0, busy = 0.
  - An in-progress scan is aborted without a done pulse.
- Manual mode (mode = 0, en = 1):
  - IDLE → load ch ← sel_in; enter GAP with counter ← gap, or go straight to ON if gap = 0.
  - ON, with sel_in ≠ ch sampled at edge t:
    - At t+1: ch ← sel_in; out = 0 if gap > 0.
    - out = one-hot(new ch) at edge t+1+gap.
  - ON, with gap = 0: out switches from the old one-hot directly to the new one-hot in one edge.
  - A sel_in change during GAP reloads ch and restarts the gap counter.
  - start is ignored; busy = 0.
- Scan mode (mode = 1, en = 1):
  - In IDLE, start = 1 → ch ← first, then GAP for gap cycles (skipped if gap = 0), then ON.
  - ON lasts max(dwell, 1) cycles.
  - After ON:
    - If ch == last: pulse done for 1 cycle, return to IDLE, out = 0.
    - Otherwise: ch ← ch + 1 modulo 2**SEL_W, then GAP.
  - Wrap-around: first > last sweeps first..2**SEL_W−1, then 0..last.
  - first == last scans exactly one channel.
  - start while busy is ignored.
  - dwell, gap and last are sampled at each GAP/ON entry; mid-scan changes take effect on the next channel.
- A mode change while not in IDLE aborts to IDLE next cycle, with out = 0 and no done pulse.
- Never more than one out bit is high. No cycle exists in which two different channels are on, except the gap = 0 direct switch.

Decomposition:
- Shared package fet_pkg holds:
  - state enum {IDLE, GAP, ON};
  - MODE_MANUAL / MODE_SCAN constants;
  - a one-hot decode function reused by the existing decoder.
- One natural sub-module: fet_onehot_dec (SEL_W → N_OUT, combinational with an out-of-range guard), registered in the parent.

Test Plan:
- Reset, then rst = 0, en = 1, mode = 0, sel_in = 3, gap = 2 → out = 0 for 2 cycles, then out = 0x00000008 with settled = 1.
- Manual change sel_in 3→17, gap = 3 → out = 0 for exactly 3 cycles, then 0x00020000; ch = 17.
- Scan first = 30, last = 1, dwell = 4, gap = 1, start pulse → sequence 30, 31, 0, 1:
  - each channel on 4 cycles, separated by 1 all-off cycle;
  - done pulses once after channel 1; busy then drops.
- Scan with dwell = 0, gap = 0, first = last = 5 → out = 0x20 for 1 cycle, then done; a second start during busy is ignored.
- en deasserted mid-scan (on channel 2) → next cycle out = 0, state IDLE, no done pulse; rst mid-GAP gives the same result.
- SEL_W = 3, N_OUT = 6, manual sel_in = 7 → out stays 0, settled = 0; scan over 4..1 skips indices 6 and 7.

Source files
------------

// File: rtl/fet_pkg.sv
// fet_pkg: shared state encoding, mode constants and decode helper for the FET select blocks
package fet_pkg;
  typedef enum logic [1:0] {IDLE, GAP, ON} state_t;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic logic fet_dec_bit(input int unsigned sel, input int unsigned pos);
    return sel == pos;
  endfunction
endpackage

// File: rtl/fet_onehot_dec.sv
// fet_onehot_dec: combinational index to one-hot decode, all zero for indices beyond N_OUT
module fet_onehot_dec import fet_pkg::*; #(
  parameter int SEL_W = 5,
  parameter int N_OUT = 2**SEL_W
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_OUT-1:0] o_oh,
  output logic             o_ok
);
  assign o_ok = 32'(i_sel) < N_OUT;
  for (genvar g = 0; g < N_OUT; g++) begin : g_bit
    assign o_oh[g] = fet_dec_bit(32'(i_sel), g);
  end
endmodule

// File: rtl/fet_sel_seq.sv
// fet_sel_seq: registered one-hot FET select with break-before-make gap, manual and scan modes
module fet_sel_seq import fet_pkg::*; #(
  parameter int SEL_W = 5,
  parameter int N_OUT = 2**SEL_W,
  parameter int DWELL_W = 16,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               start,
  input  logic [SEL_W-1:0]   first,
  input  logic [SEL_W-1:0]   last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [GAP_W-1:0]   gap,
  output logic [N_OUT-1:0]   out,
  output logic [SEL_W-1:0]   ch,
  output logic               busy,
  output logic               settled,
  output logic               done
);
  localparam int CNT_W = DWELL_W > GAP_W ? DWELL_W : GAP_W;
  state_t r_state;
  logic r_mode, r_busy, r_settled, r_done;
  logic [SEL_W-1:0] r_ch, r_last;
  logic [N_OUT-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cand;
  logic [N_OUT-1:0] w_cur_oh, w_cand_oh;
  logic [CNT_W-1:0] w_gap, w_dwell;
  logic w_cur_ok, w_cand_ok, w_scan, w_cnt_end, w_go, w_abort, w_adv, w_enter, w_finish;
  assign w_scan = mode == MODE_SCAN;
  assign w_gap = CNT_W'(gap);
  assign w_dwell = dwell == '0 ? CNT_W'(1) : CNT_W'(dwell);
  assign w_cnt_end = r_cnt <= CNT_W'(1);
  assign w_cand = !w_scan ? sel_in : r_state == IDLE ? first : r_ch + SEL_W'(1);
  assign w_go = gap == '0 && w_cand_ok;
  assign w_abort = !en || (r_state != IDLE && mode != r_mode);
  assign w_adv = (r_state == ON && w_cnt_end) || (r_state == GAP && !w_cur_ok);
  assign w_enter = w_scan ? (r_state == IDLE ? start : w_adv && r_ch != r_last)
                          : (r_state == IDLE || sel_in != r_ch);
  assign w_finish = w_scan && w_adv && r_ch == r_last;
  fet_onehot_dec #(.SEL_W(SEL_W), .N_OUT(N_OUT)) u_dec_cur (
    .i_sel(r_ch), .o_oh(w_cur_oh), .o_ok(w_cur_ok)
  );
  fet_onehot_dec #(.SEL_W(SEL_W), .N_OUT(N_OUT)) u_dec_cand (
    .i_sel(w_cand), .o_oh(w_cand_oh), .o_ok(w_cand_ok)
  );
  // Sequencer: abort/finish first, then channel (re)load, then gap expiry, then counting down
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode <= MODE_MANUAL;
      r_ch <= '0;
      r_last <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_busy <= 1'b0;
      r_settled <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort || w_finish) begin
        r_state <= IDLE;
        r_out <= '0;
        r_busy <= 1'b0;
        r_settled <= 1'b0;
        r_done <= !w_abort;
      end else if (w_enter) begin
        r_state <= w_go ? ON : GAP;
        r_mode <= mode;
        r_ch <= w_cand;
        r_last <= last;
        r_cnt <= w_go ? w_dwell : w_gap;
        r_out <= w_go ? w_cand_oh : '0;
        r_busy <= w_scan;
        r_settled <= w_go;
      end else if (r_state == GAP && w_cnt_end && w_cur_ok) begin
        r_state <= ON;
        r_last <= last;
        r_cnt <= w_dwell;
        r_out <= w_cur_oh;
        r_settled <= 1'b1;
      end else if (r_state != IDLE && !w_cnt_end) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end
  assign out = r_out;
  assign ch = r_ch;
  assign busy = r_busy;
  assign settled = r_settled;
  assign done = r_done;
endmodule

// File: tb/tb_fet_sel_seq.sv
// tb_fet_sel_seq: table and scoreboard driven checks of manual, scan, abort and narrow-config behaviour
module tb_fet_sel_seq;
  typedef struct {
    logic [31:0] out;
    logic [4:0]  ch;
    logic        chk_ch;
    logic        busy;
    logic        settled;
    logic        done;
  } exp_t;
  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic       start;
    logic [4:0] sel;
    logic [3:0] gap;
    exp_t       e;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, mode, start, en2, mode2, start2;
  logic [4:0] sel_in, first, last;
  logic [2:0] sel2, first2, last2;
  logic [15:0] dwell;
  logic [3:0] gap;
  logic [31:0] out;
  logic [4:0] ch;
  logic busy, settled, done;
  logic [5:0] out2;
  logic [2:0] ch2;
  logic busy2, settled2, done2;
  exp_t q[$];
  vec_t tv[19];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic use2 = 1'b0;
  string tag = "reset";
  fet_sel_seq dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .start(start),
    .first(first), .last(last), .dwell(dwell), .gap(gap),
    .out(out), .ch(ch), .busy(busy), .settled(settled), .done(done)
  );
  fet_sel_seq #(.SEL_W(3), .N_OUT(6)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .sel_in(sel2), .start(start2),
    .first(first2), .last(last2), .dwell(dwell), .gap(gap),
    .out(out2), .ch(ch2), .busy(busy2), .settled(settled2), .done(done2)
  );
  function automatic exp_t mk(input logic [31:0] o, input int c, input logic cc,
                              input logic b, input logic s, input logic d);
    exp_t e;
    e.out = o;
    e.ch = 5'(c);
    e.chk_ch = cc;
    e.busy = b;
    e.settled = s;
    e.done = d;
    return e;
  endfunction
  function automatic logic [31:0] oh(input int c);
    logic [31:0] one = 32'd1;
    return one << c;
  endfunction
  function automatic vec_t mkv(input logic r, input logic e, input logic m, input logic st,
                               input int s, input int g, input exp_t x);
    vec_t v;
    v.rst = r;
    v.en = e;
    v.mode = m;
    v.start = st;
    v.sel = 5'(s);
    v.gap = 4'(g);
    v.e = x;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s cyc %0d: got %0h expected %0h", tag, name, cyc, act, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s/queue cyc %0d: got empty queue expected an entry", tag, cyc);
    end else begin
      e = q.pop_front();
      chk("out", use2 ? 32'(out2) : out, e.out);
      if (e.chk_ch) chk("ch", use2 ? 32'(ch2) : 32'(ch), 32'(e.ch));
      chk("busy", 32'(use2 ? busy2 : busy), 32'(e.busy));
      chk("settled", 32'(use2 ? settled2 : settled), 32'(e.settled));
      chk("done", 32'(use2 ? done2 : done), 32'(e.done));
    end
  endtask
  task automatic drain();
    repeat (q.size()) tick();
  endtask
  task automatic push_run(input int c, input int g, input int d);
    repeat (g) q.push_back(mk(32'd0, c, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (d) q.push_back(mk(oh(c), c, 1'b1, 1'b1, 1'b1, 1'b0));
  endtask
  task automatic push_done();
    q.push_back(mk(32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask
  task automatic push_idle();
    q.push_back(mk(32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; sel_in = '0;
    first = '0; last = '0; dwell = '0; gap = '0;
    en2 = 1'b0; mode2 = 1'b0; start2 = 1'b0; sel2 = '0; first2 = '0; last2 = '0;
    tv[0]  = mkv(1, 0, 0, 0, 0, 0, mk(32'd0, 0, 1, 0, 0, 0));
    tv[1]  = mkv(0, 1, 0, 0, 3, 2, mk(32'd0, 3, 1, 0, 0, 0));
    tv[2]  = mkv(0, 1, 0, 0, 3, 2, mk(32'd0, 3, 1, 0, 0, 0));
    tv[3]  = mkv(0, 1, 0, 0, 3, 2, mk(32'h8, 3, 1, 0, 1, 0));
    tv[4]  = mkv(0, 1, 0, 0, 3, 2, mk(32'h8, 3, 1, 0, 1, 0));
    tv[5]  = mkv(0, 1, 0, 0, 17, 3, mk(32'd0, 17, 1, 0, 0, 0));
    tv[6]  = mkv(0, 1, 0, 0, 17, 3, mk(32'd0, 17, 1, 0, 0, 0));
    tv[7]  = mkv(0, 1, 0, 0, 17, 3, mk(32'd0, 17, 1, 0, 0, 0));
    tv[8]  = mkv(0, 1, 0, 0, 17, 3, mk(32'h20000, 17, 1, 0, 1, 0));
    tv[9]  = mkv(0, 1, 0, 0, 4, 0, mk(32'h10, 4, 1, 0, 1, 0));
    tv[10] = mkv(0, 1, 0, 0, 9, 2, mk(32'd0, 9, 1, 0, 0, 0));
    tv[11] = mkv(0, 1, 0, 0, 12, 2, mk(32'd0, 12, 1, 0, 0, 0));
    tv[12] = mkv(0, 1, 0, 0, 12, 2, mk(32'd0, 12, 1, 0, 0, 0));
    tv[13] = mkv(0, 1, 0, 0, 12, 2, mk(32'h1000, 12, 1, 0, 1, 0));
    tv[14] = mkv(0, 1, 0, 1, 12, 2, mk(32'h1000, 12, 1, 0, 1, 0));
    tv[15] = mkv(0, 0, 0, 0, 12, 2, mk(32'd0, 0, 0, 0, 0, 0));
    tv[16] = mkv(0, 1, 0, 0, 12, 0, mk(32'h1000, 12, 1, 0, 1, 0));
    tv[17] = mkv(0, 1, 1, 0, 12, 0, mk(32'd0, 0, 0, 0, 0, 0));
    tv[18] = mkv(0, 1, 1, 0, 12, 0, mk(32'd0, 0, 0, 0, 0, 0));
    tag = "manual";
    for (int i = 0; i < 19; i++) begin
      rst = tv[i].rst; en = tv[i].en; mode = tv[i].mode; start = tv[i].start;
      sel_in = tv[i].sel; gap = tv[i].gap;
      q.push_back(tv[i].e);
      tick();
    end
    tag = "scan_wrap";
    first = 5'd30; last = 5'd1; dwell = 16'd4; gap = 4'd1; start = 1'b1;
    push_run(30, 1, 4); push_run(31, 1, 4); push_run(0, 1, 4); push_run(1, 1, 4);
    push_done(); push_idle();
    tick();
    start = 1'b0;
    drain();
    tag = "scan_single";
    first = 5'd5; last = 5'd5; dwell = 16'd0; gap = 4'd0; start = 1'b1;
    push_run(5, 0, 1); push_done(); push_idle(); push_idle();
    tick();
    tick();
    start = 1'b0;
    drain();
    tag = "scan_abort_en";
    first = 5'd0; last = 5'd3; dwell = 16'd3; gap = 4'd1; start = 1'b1;
    push_run(0, 1, 3); push_run(1, 1, 3); push_run(2, 1, 1);
    tick();
    start = 1'b0;
    drain();
    en = 1'b0; push_idle(); tick();
    en = 1'b1; push_idle(); tick();
    tag = "scan_abort_rst";
    dwell = 16'd2; gap = 4'd3; start = 1'b1;
    push_run(0, 2, 0);
    tick();
    start = 1'b0;
    drain();
    rst = 1'b1; q.push_back(mk(32'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0)); tick();
    rst = 1'b0; push_idle(); tick();
    tag = "narrow_manual";
    en = 1'b0; use2 = 1'b1;
    en2 = 1'b1; mode2 = 1'b0; sel2 = 3'd7; gap = 4'd1;
    repeat (3) q.push_back(mk(32'd0, 7, 1'b1, 1'b0, 1'b0, 1'b0));
    drain();
    sel2 = 3'd6; q.push_back(mk(32'd0, 6, 1'b1, 1'b0, 1'b0, 1'b0)); tick();
    sel2 = 3'd5; q.push_back(mk(32'd0, 5, 1'b1, 1'b0, 1'b0, 1'b0)); tick();
    q.push_back(mk(32'h20, 5, 1'b1, 1'b0, 1'b1, 1'b0)); tick();
    mode2 = 1'b1; push_idle(); tick();
    tag = "narrow_scan";
    first2 = 3'd4; last2 = 3'd1; dwell = 16'd2; start2 = 1'b1;
    push_run(4, 1, 2); push_run(5, 1, 2);
    q.push_back(mk(32'd0, 6, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(32'd0, 7, 1'b1, 1'b1, 1'b0, 1'b0));
    push_run(0, 1, 2); push_run(1, 1, 2); push_done(); push_idle();
    tick();
    start2 = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
